// File: rtl/jtframe_db9_pkg.sv
// jtframe_db9_pkg
// Shared definitions for the DB9 joystick reader:
//   - bit positions inside the 12-bit active-high pad word
//   - pin positions inside the 6-bit per-port DB9 input slice
//   - pad classification enum and the helper that derives it
//   - sequencer state enum
package jtframe_db9_pkg;

    localparam int PAD_W = 12;
    localparam int PIN_W = 6;

    // Pad word layout {mode,x,y,z,start,c,b,a,right,left,up,down}
    localparam int BTN_DOWN  = 0;
    localparam int BTN_UP    = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_Z     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_X     = 10;
    localparam int BTN_MODE  = 11;

    // DB9 input slice layout {p9,p6,right,left,up,down}
    localparam int PIN_DOWN  = 0;
    localparam int PIN_UP    = 1;
    localparam int PIN_LEFT  = 2;
    localparam int PIN_RIGHT = 3;
    localparam int PIN_P6    = 4;
    localparam int PIN_P9    = 5;

    typedef enum logic [1:0] {
        PAD_NONE = 2'b00,   // Atari / 2-button stick, or nothing connected
        PAD_3B   = 2'b01,   // Sega 3-button
        PAD_6B   = 2'b10    // Sega 6-button
    } pad_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } seq_state_e;

    // A Sega pad pulls left and right low together while select is low;
    // a 6-button pad additionally grounds all four directions in phase 5.
    function automatic pad_type_e pad_class(input logic present, input logic six);
        if (!present) begin
            return PAD_NONE;
        end else if (six) begin
            return PAD_6B;
        end else begin
            return PAD_3B;
        end
    endfunction

endpackage

// File: rtl/jtframe_db9_port.sv
// jtframe_db9_port
// Per-port sample latches and publish logic. The shared sequencer in the
// top level tells this block when to capture each phase and when to
// publish; all ports therefore publish on the same cycle.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   pins_i          synchronised active-high pins {p9,p6,right,left,up,down}
//   smp_ph0_i ..    one-cycle capture strobes for select phases 0, 1, 5, 6
//   publish_i       one-cycle strobe: load pad_o/pad_type_o from the latches
//   pad_o           active-high button word {mode,x,y,z,start,c,b,a,R,L,U,D}
//   pad_type_o      00 none/Atari, 01 Sega 3-button, 10 Sega 6-button
module jtframe_db9_port
    import jtframe_db9_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [PIN_W-1:0] pins_i,
    input  logic             smp_ph0_i,
    input  logic             smp_ph1_i,
    input  logic             smp_ph5_i,
    input  logic             smp_ph6_i,
    input  logic             publish_i,
    output logic [PAD_W-1:0] pad_o,
    output logic [1:0]       pad_type_o
);

    logic [3:0]       dir_d, dir_q;     // {right,left,up,down}
    logic             b_d, b_q;
    logic             c_d, c_q;
    logic             a_d, a_q;
    logic             start_d, start_q;
    logic             present_d, present_q;
    logic             six_d, six_q;
    logic [3:0]       ext_d, ext_q;     // {mode,x,y,z}
    logic [PAD_W-1:0] word;
    logic [PAD_W-1:0] pad_d, pad_q;
    pad_type_e        frame_type;
    pad_type_e        type_d, type_q;

    always_comb begin
        dir_d     = dir_q;
        b_d       = b_q;
        c_d       = c_q;
        a_d       = a_q;
        start_d   = start_q;
        present_d = present_q;
        six_d     = six_q;
        ext_d     = ext_q;

        if (smp_ph0_i) begin
            dir_d = pins_i[PIN_RIGHT:PIN_DOWN];
            b_d   = pins_i[PIN_P6];
            c_d   = pins_i[PIN_P9];
        end
        if (smp_ph1_i) begin
            present_d = pins_i[PIN_LEFT] & pins_i[PIN_RIGHT];
            a_d       = pins_i[PIN_P6];
            start_d   = pins_i[PIN_P9];
        end
        if (smp_ph5_i) begin
            six_d = &pins_i[PIN_RIGHT:PIN_DOWN];
        end
        if (smp_ph6_i) begin
            // Phase 6 reuses the direction lines: Z=up, Y=down, X=left, MODE=right
            ext_d = {pins_i[PIN_RIGHT], pins_i[PIN_LEFT], pins_i[PIN_DOWN], pins_i[PIN_UP]};
        end
    end

    // Every latch is rewritten each frame before the publish strobe, so the
    // latches themselves carry no reset.
    always_ff @(posedge clk) begin
        dir_q     <= dir_d;
        b_q       <= b_d;
        c_q       <= c_d;
        a_q       <= a_d;
        start_q   <= start_d;
        present_q <= present_d;
        six_q     <= six_d;
        ext_q     <= ext_d;
    end

    // Assemble the frame word. For a plain stick the two fire buttons on
    // p6/p9 land in b/c and a/start stay clear.
    always_comb begin
        frame_type = pad_class(present_q, six_q);
        word       = '0;
        word[BTN_RIGHT:BTN_DOWN] = dir_q;
        word[BTN_B]              = b_q;
        word[BTN_C]              = c_q;
        if (frame_type != PAD_NONE) begin
            word[BTN_A]     = a_q;
            word[BTN_START] = start_q;
        end
        if (frame_type == PAD_6B) begin
            word[BTN_MODE:BTN_Z] = ext_q;
        end
        pad_d  = publish_i ? word : pad_q;
        type_d = publish_i ? frame_type : type_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pad_q  <= '0;
            type_q <= PAD_NONE;
        end else begin
            pad_q  <= pad_d;
            type_q <= type_d;
        end
    end

    assign pad_o      = pad_q;
    assign pad_type_o = type_q;

endmodule

// File: rtl/jtframe_db9_pads.sv
// jtframe_db9_pads
// Multi-port DB9 joystick reader. One shared select line runs the Sega
// 8-phase protocol on all ports at once; each port is classified and its
// button word published atomically once per scan frame.
// Frame = IDLE_CYC cycles with select high, then 8 phases of PHASE_CYC.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   db9_i        raw active-low pins, port n at [6n+5:6n] = {p9,p6,R,L,U,D}
//   sel_o        shared select line (pin 7)
//   pad_o        active-high words, port n at [12n+11:12n]
//   pad_type_o   classification, port n at [2n+1:2n]
//   frame_done   one-cycle pulse on the cycle pad_o/pad_type_o change
module jtframe_db9_pads
    import jtframe_db9_pkg::*;
#(
    parameter int PORTS     = 2,
    parameter int PHASE_CYC = 480,
    parameter int IDLE_CYC  = 96000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PORTS*PIN_W-1:0] db9_i,
    output logic                   sel_o,
    output logic [PORTS*PAD_W-1:0] pad_o,
    output logic [PORTS*2-1:0]     pad_type_o,
    output logic                   frame_done
);

    localparam int PH_W   = $clog2(PHASE_CYC);
    localparam int IDLE_W = $clog2(IDLE_CYC);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(PHASE_CYC - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);

    // Input synchroniser; inverted afterwards so everything downstream is
    // active-high.
    logic [PORTS*PIN_W-1:0] meta_d, meta_q;
    logic [PORTS*PIN_W-1:0] sync_d, sync_q;
    logic [PORTS*PIN_W-1:0] pins_hi;

    always_comb begin
        meta_d = db9_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        meta_q <= meta_d;
        sync_q <= sync_d;
    end

    assign pins_hi = ~sync_q;

    // Sequencer
    seq_state_e        state_d, state_q;
    logic [IDLE_W-1:0] idle_cnt_d, idle_cnt_q;
    logic [PH_W-1:0]   ph_cyc_d, ph_cyc_q;
    logic [2:0]        phase_d, phase_q;
    logic              sel_d, sel_q;
    logic              frame_done_d, frame_done_q;
    logic              phase_end;
    logic              publish;
    logic              smp_ph0, smp_ph1, smp_ph5, smp_ph6;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        ph_cyc_d   = ph_cyc_q;
        phase_d    = phase_q;
        publish    = 1'b0;
        phase_end  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (idle_cnt_q == IDLE_LAST) begin
                    idle_cnt_d = '0;
                    ph_cyc_d   = '0;
                    phase_d    = 3'd0;
                    state_d    = ST_SCAN;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            ST_SCAN: begin
                if (ph_cyc_q == PH_LAST) begin
                    // Last cycle of the phase: the pins have had PHASE_CYC-1
                    // cycles to settle since the select edge.
                    phase_end = 1'b1;
                    ph_cyc_d  = '0;
                    phase_d   = phase_q + 3'd1;
                    if (phase_q == 3'd7) begin
                        publish = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    ph_cyc_d = ph_cyc_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        smp_ph0 = phase_end && (phase_q == 3'd0);
        smp_ph1 = phase_end && (phase_q == 3'd1);
        smp_ph5 = phase_end && (phase_q == 3'd5);
        smp_ph6 = phase_end && (phase_q == 3'd6);

        // Select is registered from the next state so the pin never glitches.
        sel_d        = (state_d == ST_IDLE) || !phase_d[0];
        frame_done_d = publish;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idle_cnt_q   <= '0;
            ph_cyc_q     <= '0;
            phase_q      <= 3'd0;
            sel_q        <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            ph_cyc_q     <= ph_cyc_d;
            phase_q      <= phase_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sel_o      = sel_q;
    assign frame_done = frame_done_q;

    for (genvar n = 0; n < PORTS; n++) begin : g_port
        jtframe_db9_port u_port (
            .clk        (clk),
            .rst        (rst),
            .pins_i     (pins_hi[PIN_W*n +: PIN_W]),
            .smp_ph0_i  (smp_ph0),
            .smp_ph1_i  (smp_ph1),
            .smp_ph5_i  (smp_ph5),
            .smp_ph6_i  (smp_ph6),
            .publish_i  (publish),
            .pad_o      (pad_o[PAD_W*n +: PAD_W]),
            .pad_type_o (pad_type_o[2*n +: 2])
        );
    end

endmodule
